// File: rtl/p_addsub_pipe_if.sv
// Request/response bundle for the sliced SIMD add/subtract unit.
// master drives requests and the response ready; slave is the datapath side.
interface p_addsub_pipe_if #(
    parameter int XLEN = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   lhs;
    logic [XLEN-1:0]   rhs;
    logic [2:0]        lw;
    logic              sub;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   result;
    logic [XLEN/2-1:0] c_out;
    logic              err;

    modport master (
        output in_valid, lhs, rhs, lw, sub, cin, out_ready,
        input  in_ready, out_valid, result, c_out, err
    );

    modport slave (
        input  in_valid, lhs, rhs, lw, sub, cin, out_ready,
        output in_ready, out_valid, result, c_out, err
    );
endinterface

// File: rtl/p_addsub_pipe.sv
// Packed SIMD add/subtract, one SEG-bit slice per cycle, LSB slice first.
// Lane width is 2^lw bits; carries are cut at every lane boundary.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request, in_ready=1
// BUSY  | processing slice cnt_q, XLEN/SEG cycles in total
// DONE  | result presented with out_valid=1 until out_ready
module p_addsub_pipe #(
    parameter int XLEN = 64,
    parameter int SEG  = 16
) (
    input logic             clock,
    input logic             reset,
    p_addsub_pipe_if.slave  bus
);
    localparam int NSLICE = XLEN / SEG;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int KW     = $clog2(XLEN);
    localparam int LW     = XLEN / 2;
    localparam int LIW    = $clog2(LW);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] lhs_q, rhs_q, opb;
    logic [2:0]      lw_q;
    logic            sub_q, cin_q;
    logic [1:0]      carry_q, carry_d, lane_cin;
    logic [XLEN-1:0] res_acc, res_next, result_q;
    logic [LW-1:0]   cout_acc, cout_next, c_out_q;
    logic            err_q;
    logic            in_ready, out_valid, accept, last_slice;
    logic            illegal, full_lane;
    logic [31:0]     lane_mask;
    int              bit_idx;
    logic [2:0]      bit_sum;

    assign illegal    = (lw_q == 3'd0) || (int'(lw_q) > KW);
    assign full_lane  = (int'(lw_q) == KW);
    assign lane_mask  = (32'd1 << lw_q) - 32'd1;
    // Full-width lanes may need sub and cin together at bit 0, so the carry is 2 bits wide.
    assign lane_cin   = full_lane ? ({1'b0, sub_q} + {1'b0, cin_q}) : {1'b0, sub_q};
    assign opb        = sub_q ? ~rhs_q : rhs_q;
    assign last_slice = (cnt_q == LAST);
    assign accept     = bus.in_valid & in_ready;

    // Ripple the current slice bit by bit, reloading the carry at each lane start.
    always_comb begin
        res_next  = res_acc;
        cout_next = cout_acc;
        carry_d   = carry_q;
        bit_idx   = 0;
        bit_sum   = '0;
        for (int j = 0; j < SEG; j++) begin
            bit_idx = int'(cnt_q) * SEG + j;
            if ((bit_idx & lane_mask) == 0) carry_d = lane_cin;
            bit_sum = {2'b00, lhs_q[KW'(bit_idx)]} + {2'b00, opb[KW'(bit_idx)]} + {1'b0, carry_d};
            res_next[KW'(bit_idx)] = bit_sum[0];
            carry_d = bit_sum[2:1];
            if ((((bit_idx + 1) & lane_mask) == 0) && (lw_q != 3'd0))
                cout_next[LIW'(bit_idx >> lw_q)] = bit_sum[1];
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~reset;
                if (bus.in_valid && !reset) state_d = BUSY;
            end
            BUSY: begin
                if (last_slice) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    in_ready = ~reset;
                    state_d  = bus.in_valid ? BUSY : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, operand capture, slice accumulation and output load.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lhs_q    <= '0;
            rhs_q    <= '0;
            lw_q     <= '0;
            sub_q    <= 1'b0;
            cin_q    <= 1'b0;
            carry_q  <= '0;
            res_acc  <= '0;
            cout_acc <= '0;
            result_q <= '0;
            c_out_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lhs_q    <= bus.lhs;
                rhs_q    <= bus.rhs;
                lw_q     <= bus.lw;
                sub_q    <= bus.sub;
                cin_q    <= bus.cin;
                cnt_q    <= '0;
                carry_q  <= '0;
                cout_acc <= '0;
            end else if (state_q == BUSY) begin
                cnt_q    <= last_slice ? '0 : cnt_q + 1'b1;
                carry_q  <= carry_d;
                res_acc  <= res_next;
                cout_acc <= cout_next;
                if (last_slice) begin
                    result_q <= illegal ? '0 : res_next;
                    c_out_q  <= illegal ? '0 : cout_next;
                    err_q    <= illegal;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.c_out     = c_out_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_p_addsub_pipe.sv
// Directed bench for p_addsub_pipe (XLEN=64, SEG=16, latency 4).
module tb_p_addsub_pipe;
    logic clock = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    p_addsub_pipe_if #(.XLEN(64)) bus();

    p_addsub_pipe #(.XLEN(64), .SEG(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] lw, input logic s, input logic ci,
                             input logic [63:0] a, input logic [63:0] b);
        bus.in_valid = 1'b1;
        bus.lw       = lw;
        bus.sub      = s;
        bus.cin      = ci;
        bus.lhs      = a;
        bus.rhs      = b;
    endtask

    // Junk on the inputs after accept; the unit must ignore it.
    task automatic scramble();
        bus.in_valid = 1'b0;
        bus.lhs      = 64'hDEAD_BEEF_1234_5678;
        bus.rhs      = 64'h0F0F_7777_8888_F0F0;
        bus.lw       = 3'd2;
        bus.sub      = ~bus.sub;
        bus.cin      = ~bus.cin;
    endtask

    task automatic run_op(input string tag, input logic [2:0] lw, input logic s, input logic ci,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input logic [31:0] exp_cout, input logic exp_err);
        int early;
        @(negedge clock);
        drive_req(lw, s, ci, a, b);
        #1;
        check_val({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clock);
        @(negedge clock);
        scramble();
        early = bus.out_valid ? 1 : 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.out_valid) early++;
        end
        check_val({tag, ".early_valid"}, 64'(early), 64'd0);
        @(negedge clock);
        check_val({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        check_val({tag, ".result"}, bus.result, exp_res);
        check_val({tag, ".c_out"}, 64'(bus.c_out), 64'(exp_cout));
        check_val({tag, ".err"}, 64'(bus.err), 64'(exp_err));
        @(negedge clock);
        check_val({tag, ".idle_valid"}, 64'(bus.out_valid), 64'd0);
        check_val({tag, ".hold"}, bus.result, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.lhs       = '0;
        bus.rhs       = '0;
        bus.lw        = '0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rst.in_ready", 64'(bus.in_ready), 64'd0);
        check_val("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst.result", bus.result, 64'd0);
        check_val("rst.c_out", 64'(bus.c_out), 64'd0);
        check_val("rst.err", 64'(bus.err), 64'd0);
        reset = 1'b0;
        #1;
        check_val("rel.in_ready", 64'(bus.in_ready), 64'd1);

        run_op("wrap64", 3'd6, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
               64'h0, 32'h1, 1'b0);
        run_op("sub8", 3'd3, 1'b1, 1'b0, 64'h0, 64'h0101_0101_0101_0101,
               64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 1'b0);
        run_op("add16", 3'd4, 1'b0, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001,
               64'h0000_0001_0000_0001, 32'hA, 1'b0);
        run_op("cin64", 3'd6, 1'b0, 1'b1, 64'h0000_FFFF_0000_FFFF, 64'h1,
               64'h0000_FFFF_0001_0001, 32'h0, 1'b0);
        run_op("sub64", 3'd6, 1'b1, 1'b0, 64'h5, 64'h3,
               64'h2, 32'h1, 1'b0);
        run_op("sub64cin", 3'd6, 1'b1, 1'b1, 64'h5, 64'h3,
               64'h3, 32'h1, 1'b0);
        run_op("add2", 3'd1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555,
               64'h0, 32'hFFFF_FFFF, 1'b0);
        run_op("lw0", 3'd0, 1'b0, 1'b0, 64'h5, 64'h3,
               64'h0, 32'h0, 1'b1);

        // Backpressure: three DONE cycles with out_ready low, then back-to-back accept.
        @(negedge clock);
        bus.out_ready = 1'b0;
        drive_req(3'd4, 1'b0, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001);
        @(posedge clock);
        @(negedge clock);
        scramble();
        repeat (3) @(negedge clock);
        @(negedge clock);
        drive_req(3'd6, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            check_val("bp.out_valid", 64'(bus.out_valid), 64'd1);
            check_val("bp.in_ready", 64'(bus.in_ready), 64'd0);
            check_val("bp.result", bus.result, 64'h0000_0001_0000_0001);
            check_val("bp.c_out", 64'(bus.c_out), 64'hA);
        end
        bus.out_ready = 1'b1;
        #1;
        check_val("bp.release_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clock);
        check_val("bp.b2b_valid", 64'(bus.out_valid), 64'd0);
        scramble();
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.out_valid) seen++;
        end
        check_val("bp.b2b_early", 64'(seen), 64'd0);
        @(negedge clock);
        check_val("bp.b2b_done", 64'(bus.out_valid), 64'd1);
        check_val("bp.b2b_result", bus.result, 64'h0);
        check_val("bp.b2b_c_out", 64'(bus.c_out), 64'h1);

        run_op("lane32", 3'd5, 1'b0, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'h0000_0001_0000_0001,
               64'h0000_0002_0000_0000, 32'h1, 1'b0);

        // Reset in the middle of BUSY (slice 2): the operation must vanish.
        @(negedge clock);
        drive_req(3'd6, 1'b0, 1'b0, 64'h1, 64'h1);
        @(posedge clock);
        @(negedge clock);
        scramble();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_val("mid.rst_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clock);
        check_val("mid.out_valid", 64'(bus.out_valid), 64'd0);
        check_val("mid.result", bus.result, 64'd0);
        check_val("mid.c_out", 64'(bus.c_out), 64'd0);
        reset = 1'b0;
        #1;
        check_val("mid.in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.out_valid) seen++;
        end
        check_val("mid.discarded", 64'(seen), 64'd0);

        run_op("lw7", 3'd7, 1'b0, 1'b0, 64'h1234, 64'h1,
               64'h0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
